// File: rtl/avg_pool_2d_ctrl.sv
// 2x2 window gatherer for average pooling: buffers even rows in a line buffer and emits
// {top-left, top-right, bottom-left, bottom-right} per fmap through a valid/ready output register.
module avg_pool_2d_ctrl #(
    parameter int unsigned NBITS  = 32,
    parameter int unsigned NFMAPS = 32,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NBITS*NFMAPS-1:0]    in_act,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [NBITS*4*NFMAPS-1:0]  win_act,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       frame_done
);

    localparam int unsigned PW = NBITS * NFMAPS;
    localparam int unsigned CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

    typedef enum logic [0:0] {StRowTop, StRowBot} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic                     win_valid_q, win_valid_d;
    logic                     last_q, last_d;
    logic [NBITS*4*NFMAPS-1:0] win_act_q;
    logic [PW-1:0]            hold_q;
    logic [PW-1:0]            linebuf_q [IMG_W];

    logic in_xfer, win_xfer, load, col_end;
    logic [CW-1:0] col_left;

    assign win_xfer = win_valid_q & win_ready;
    // Stall only when a completing pixel would overwrite a window nobody is taking this cycle.
    assign in_ready = !((state_q == StRowBot) && col_q[0] && win_valid_q && !win_ready);
    assign in_xfer  = in_valid & in_ready;
    assign load     = in_xfer && (state_q == StRowBot) && col_q[0];
    assign col_end  = (col_q == ColLast);
    assign col_left = col_q - CW'(1);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = win_valid_q;
        last_d      = last_q;
        if (in_xfer) begin
            if (col_end) begin
                col_d   = '0;
                state_d = (state_q == StRowTop) ? StRowBot : StRowTop;
                row_d   = (row_q == RowLast) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (load) begin
            win_valid_d = 1'b1;
            last_d      = col_end && (row_q == RowLast);
        end else if (win_xfer) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRowTop;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            last_q      <= last_d;
        end
    end

    // Data storage carries no reset; contents are qualified by win_valid.
    always_ff @(posedge clk) begin
        if (in_xfer && (state_q == StRowTop)) begin
            linebuf_q[col_q] <= in_act;
        end
        if (in_xfer && (state_q == StRowBot) && !col_q[0]) begin
            hold_q <= in_act;
        end
        if (load) begin
            for (int unsigned f = 0; f < NFMAPS; f++) begin
                win_act_q[(f*4+0)*NBITS +: NBITS] <= linebuf_q[col_left][f*NBITS +: NBITS];
                win_act_q[(f*4+1)*NBITS +: NBITS] <= linebuf_q[col_q][f*NBITS +: NBITS];
                win_act_q[(f*4+2)*NBITS +: NBITS] <= hold_q[f*NBITS +: NBITS];
                win_act_q[(f*4+3)*NBITS +: NBITS] <= in_act[f*NBITS +: NBITS];
            end
        end
    end

    assign win_act    = win_act_q;
    assign win_valid  = win_valid_q;
    assign frame_done = win_xfer & last_q;

endmodule

// File: tb/tb_avg_pool_2d_ctrl.sv
// Randomized bench for avg_pool_2d_ctrl: an image-level scoreboard predicts every window,
// the ready/valid handshake and frame_done; scenario tasks add targeted checks.
module tb_avg_pool_2d_ctrl;

    localparam int NB = 8;
    localparam int NF = 2;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = NB * NF;
    localparam int WW = NB * 4 * NF;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] in_act;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] win_act;
    logic          win_valid;
    logic          win_ready;
    logic          frame_done;

    avg_pool_2d_ctrl #(.NBITS(NB), .NFMAPS(NF), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_act     (in_act),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .win_act    (win_act),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] data;
        bit            last;
    } win_t;

    int n_tests = 0;
    int n_fail  = 0;
    int win_seen = 0;
    int done_seen = 0;
    int stall_cnt = 0;
    int cyc = 0;
    bit rand_bp = 0;

    win_t          exp_q [$];
    logic [PW-1:0] img [H][W];
    int            mr = 0;
    int            mc = 0;

    function automatic logic [WW-1:0] make_win(input logic [PW-1:0] tl, input logic [PW-1:0] tr,
                                               input logic [PW-1:0] bl, input logic [PW-1:0] br);
        logic [WW-1:0] w;
        for (int f = 0; f < NF; f++) begin
            w[(f*4+0)*NB +: NB] = tl[f*NB +: NB];
            w[(f*4+1)*NB +: NB] = tr[f*NB +: NB];
            w[(f*4+2)*NB +: NB] = bl[f*NB +: NB];
            w[(f*4+3)*NB +: NB] = br[f*NB +: NB];
        end
        return w;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (rand_bp) begin
            #1 win_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: image positions are tracked from accepted pixels; a window is expected once its
    // bottom-right pixel is accepted, and it stays at the queue head until it is consumed.
    always @(negedge clk) begin
        bit   exp_valid, exp_ready, exp_done;
        win_t w;
        if (rst) begin
            exp_q.delete();
            mr = 0;
            mc = 0;
        end else begin
            exp_valid = (exp_q.size() != 0);
            exp_ready = !(exp_valid && !win_ready && (mr % 2 == 1) && (mc % 2 == 1));
            exp_done  = 1'b0;
            n_tests++;
            if (win_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL win_valid @%0t: got %b expected %b", $time, win_valid, exp_valid);
            end
            n_tests++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL in_ready @%0t: got %b expected %b", $time, in_ready, exp_ready);
            end
            if (exp_valid) begin
                n_tests++;
                if (win_act !== exp_q[0].data) begin
                    n_fail++;
                    $display("FAIL win_act @%0t: got %h expected %h", $time, win_act,
                             exp_q[0].data);
                end
                if (win_ready) begin
                    exp_done = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
            end
            n_tests++;
            if (frame_done !== exp_done) begin
                n_fail++;
                $display("FAIL frame_done @%0t: got %b expected %b", $time, frame_done, exp_done);
            end
            if (win_valid === 1'b1 && win_ready === 1'b1) win_seen++;
            if (frame_done === 1'b1) done_seen++;
            if (in_valid && exp_ready) begin
                img[mr][mc] = in_act;
                if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                    w.data = make_win(img[mr-1][mc-1], img[mr-1][mc], img[mr][mc-1], in_act);
                    w.last = (mr == H - 1) && (mc == W - 1);
                    exp_q.push_back(w);
                end
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr = (mr == H - 1) ? 0 : mr + 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_pixel(input logic [PW-1:0] d);
        int n = 0;
        in_act   = d;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            stall_cnt++;
            n++;
            if (n > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_pixel(PW'($urandom));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        win_ready = 1'b0;
        send_random(6);
        do_reset();
        @(negedge clk);
        n_tests++;
        if (win_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_win_valid: got %b expected 0", win_valid);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_tests++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_frame_done: got %b expected 0", frame_done);
        end
        win_ready = 1'b1;
    endtask

    task automatic test_basic_frame();
        int w0 = win_seen;
        int d0 = done_seen;
        do_reset();
        win_ready = 1'b1;
        for (int i = 1; i <= 16; i++) send_pixel({8'($urandom), 8'(i)});
        idle(3);
        n_tests++;
        if (win_seen - w0 != 4) begin
            n_fail++;
            $display("FAIL basic_windows: got %0d expected 4", win_seen - w0);
        end
        n_tests++;
        if (done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_frame_done: got %0d expected 1", done_seen - d0);
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] p [8];
        logic [WW-1:0] exp_w;
        do_reset();
        win_ready = 1'b1;
        for (int i = 0; i < 8; i++) p[i] = {8'($urandom), 8'(i + 1)};
        for (int i = 0; i < 6; i++) send_pixel(p[i]);
        win_ready = 1'b0;
        send_pixel(p[6]);
        in_act   = p[7];
        in_valid = 1'b1;
        exp_w    = make_win(p[0], p[1], p[4], p[5]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b0 || win_valid !== 1'b1 || win_act !== exp_w) begin
                n_fail++;
                $display("FAIL bp_hold: in_ready=%b win_valid=%b win_act=%h, required 0 1 %h",
                         in_ready, win_valid, win_act, exp_w);
            end
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_w    = make_win(p[2], p[3], p[6], p[7]);
        @(negedge clk);
        n_tests++;
        if (win_valid !== 1'b1 || win_act !== exp_w) begin
            n_fail++;
            $display("FAIL bp_release: win_valid=%b win_act=%h, required 1 %h",
                     win_valid, win_act, exp_w);
        end
    endtask

    task automatic test_signed();
        do_reset();
        win_ready = 1'b1;
        send_pixel({8'($urandom), 8'h80});
        send_pixel({8'($urandom), 8'h7F});
        send_random(2);
        send_pixel({8'($urandom), 8'hFF});
        send_pixel({8'($urandom), 8'h00});
        @(negedge clk);
        n_tests++;
        if (win_valid !== 1'b1 || win_act[31:0] !== 32'h00FF_7F80) begin
            n_fail++;
            $display("FAIL signed_slots: valid=%b slots=%h, required 1 00ff7f80",
                     win_valid, win_act[31:0]);
        end
        send_random(10);
    endtask

    task automatic test_back_to_back();
        int w0 = win_seen;
        int d0 = done_seen;
        int s0 = stall_cnt;
        int c0;
        do_reset();
        win_ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 2 * W * H; i++) begin
            in_act   = PW'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready !== 1'b1) stall_cnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_tests++;
        if (cyc - c0 != 2 * W * H || stall_cnt != s0) begin
            n_fail++;
            $display("FAIL b2b_throughput: cycles=%0d stalls=%0d, required %0d 0",
                     cyc - c0, stall_cnt - s0, 2 * W * H);
        end
        idle(3);
        n_tests++;
        if (win_seen - w0 != 8) begin
            n_fail++;
            $display("FAIL b2b_windows: got %0d expected 8", win_seen - w0);
        end
        n_tests++;
        if (done_seen - d0 != 2) begin
            n_fail++;
            $display("FAIL b2b_frame_done: got %0d expected 2", done_seen - d0);
        end
    endtask

    task automatic test_mid_reset();
        int w0;
        int d0;
        do_reset();
        win_ready = 1'b0;
        send_random(6);
        do_reset();
        win_ready = 1'b1;
        w0 = win_seen;
        d0 = done_seen;
        send_random(W * H);
        idle(3);
        n_tests++;
        if (win_seen - w0 != 4 || done_seen - d0 != 1) begin
            n_fail++;
            $display("FAIL midreset_counts: windows=%0d done=%0d, required 4 1",
                     win_seen - w0, done_seen - d0);
        end
    endtask

    task automatic test_idle_gaps();
        int w0 = win_seen;
        int d0 = done_seen;
        do_reset();
        win_ready = 1'b1;
        for (int i = 0; i < 2 * W * H; i++) begin
            idle($urandom_range(0, 2));
            send_pixel(PW'($urandom));
        end
        idle(3);
        n_tests++;
        if (win_seen - w0 != 8 || done_seen - d0 != 2) begin
            n_fail++;
            $display("FAIL gaps_counts: windows=%0d done=%0d, required 8 2",
                     win_seen - w0, done_seen - d0);
        end
    endtask

    task automatic test_random_bp();
        int w0 = win_seen;
        int d0 = done_seen;
        do_reset();
        rand_bp = 1'b1;
        for (int i = 0; i < 2 * W * H; i++) begin
            idle($urandom_range(0, 1));
            send_pixel(PW'($urandom));
        end
        rand_bp = 1'b0;
        #2;
        win_ready = 1'b1;
        idle(4);
        n_tests++;
        if (win_seen - w0 != 8 || done_seen - d0 != 2) begin
            n_fail++;
            $display("FAIL randbp_counts: windows=%0d done=%0d, required 8 2",
                     win_seen - w0, done_seen - d0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_act    = '0;
        win_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_signed();
        test_back_to_back();
        test_mid_reset();
        test_idle_gaps();
        test_random_bp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
